// File: rtl/oldland_tlb_array.sv
// Fully-associative TLB array: registered lookup, load with duplicate
// replace and round-robin victim, single-entry invalidate and flush-all.
module oldland_tlb_array #(
   parameter int ENTRIES    = 8,
   parameter int PAGE_SHIFT = 12,
   parameter int IDX_BITS   = $clog2(ENTRIES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  lookup_req,
   input  logic [31-PAGE_SHIFT:0] lookup_virt,
   input  logic                  user_mode,
   output logic                  lookup_done,
   output logic                  lookup_hit,
   output logic [31-PAGE_SHIFT:0] lookup_phys,
   output logic [1:0]            lookup_access,
   output logic [IDX_BITS-1:0]   lookup_idx,
   input  logic                  load,
   input  logic [31-PAGE_SHIFT:0] load_virt,
   input  logic [31-PAGE_SHIFT:0] load_phys,
   input  logic [3:0]            load_access,
   input  logic                  inval_one,
   input  logic [31-PAGE_SHIFT:0] inval_virt,
   input  logic                  inval_all,
   output logic [IDX_BITS-1:0]   victim_idx
);

   localparam int W = 32 - PAGE_SHIFT;

   logic          valid  [ENTRIES];
   logic [W-1:0]  virt   [ENTRIES];
   logic [W-1:0]  phys   [ENTRIES];
   logic [3:0]    access [ENTRIES];
   logic [IDX_BITS-1:0] ptr;

   logic                lk_hit;
   logic [IDX_BITS-1:0] lk_idx;
   logic [W-1:0]        lk_phys;
   logic [1:0]          lk_acc;

   logic                dup_hit;
   logic [IDX_BITS-1:0] dup_idx;
   logic                free_hit;
   logic [IDX_BITS-1:0] free_idx;
   logic                inv_hit;
   logic [IDX_BITS-1:0] inv_idx;
   logic [IDX_BITS-1:0] target;
   logic                advance;

   assign victim_idx = ptr;

   // At most one valid entry per VPN, so the match loop never sees multi-hit.
   always_comb begin
      lk_hit  = 1'b0;
      lk_idx  = '0;
      lk_phys = '0;
      lk_acc  = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (valid[i] && virt[i] == lookup_virt) begin
            lk_hit  = 1'b1;
            lk_idx  = IDX_BITS'(i);
            lk_phys = phys[i];
            lk_acc  = user_mode ? access[i][3:2] : access[i][1:0];
         end
      end
   end

   always_comb begin
      dup_hit  = 1'b0;
      dup_idx  = '0;
      free_hit = 1'b0;
      free_idx = '0;
      inv_hit  = 1'b0;
      inv_idx  = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (valid[i] && virt[i] == load_virt) begin
            dup_hit = 1'b1;
            dup_idx = IDX_BITS'(i);
         end
         if (!valid[i] && !free_hit) begin
            free_hit = 1'b1;
            free_idx = IDX_BITS'(i);
         end
         if (valid[i] && virt[i] == inval_virt) begin
            inv_hit = 1'b1;
            inv_idx = IDX_BITS'(i);
         end
      end
   end

   assign advance = !dup_hit && !free_hit;
   assign target  = dup_hit  ? dup_idx :
                    free_hit ? free_idx : ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid[i]  <= 1'b0;
            virt[i]   <= '0;
            phys[i]   <= '0;
            access[i] <= '0;
         end
         ptr           <= '0;
         lookup_done   <= 1'b0;
         lookup_hit    <= 1'b0;
         lookup_phys   <= '0;
         lookup_access <= '0;
         lookup_idx    <= '0;
      end else begin
         lookup_done <= lookup_req;
         if (lookup_req) begin
            lookup_hit    <= lk_hit;
            lookup_phys   <= lk_phys;
            lookup_access <= lk_acc;
            lookup_idx    <= lk_idx;
         end
         if (inval_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
               valid[i]  <= 1'b0;
               virt[i]   <= '0;
               phys[i]   <= '0;
               access[i] <= '0;
            end
         end else begin
            if (load) begin
               valid[target]  <= 1'b1;
               virt[target]   <= load_virt;
               phys[target]   <= load_phys;
               access[target] <= load_access;
               if (advance)
                  ptr <= (ptr == IDX_BITS'(ENTRIES - 1)) ? '0 : ptr + 1'b1;
            end
            // Issued after the load so a same-entry collision ends invalid.
            if (inval_one && inv_hit)
               valid[inv_idx] <= 1'b0;
         end
      end
   end

endmodule
